// File: rtl/timing_constants.sv
// Timing constants and frame state encoding shared by the WS2812 frame controller,
// the reshaper and the encoder.
package timing_constants;

  localparam int unsigned RESET_CYCLES           = 2500;
  localparam int unsigned BIT1_THRESHOLD         = 32;
  // Shortest legal high time the encoder ever produces; anything shorter is noise.
  localparam int unsigned T0H_CYCLES_ENCODER_MIN = 8;

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    HIGH,
    LOW,
    PASS
  } frame_state_t;

endpackage

// File: rtl/ws2812_frame_ctrl_if.sv
// Signals between the input synchronizer, the frame controller and the reshaper.
// master: the frame controller side; slave: the surrounding pixel node.
interface ws2812_frame_ctrl_if #(
  parameter int unsigned BITS_PER_PIXEL = 24
) ();

  logic                      i_signal_synced;
  logic                      o_passthru_en;
  logic [BITS_PER_PIXEL-1:0] o_pixel;
  logic                      o_pixel_valid;
  logic                      o_frame_err;

  modport master (
    input  i_signal_synced,
    output o_passthru_en,
    output o_pixel,
    output o_pixel_valid,
    output o_frame_err
  );

  modport slave (
    output i_signal_synced,
    input  o_passthru_en,
    input  o_pixel,
    input  o_pixel_valid,
    input  o_frame_err
  );

endinterface

// File: rtl/pulse_timer.sv
// Level tracker for the synchronized WS2812 line: edge flags plus a saturating
// run-length counter of the current level.
module pulse_timer #(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sig_i,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic             level_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q is the number of cycles level_q has been held, counting the edge cycle as 1.
  always_comb begin
    cnt_d = cnt_q;
    if (sig_i != level_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= sig_i;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = sig_i & ~level_q;
  assign fall_o  = ~sig_i & level_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame controller: captures this node's pixel, then enables passthrough until latch.
// Optional high-glitch rejection is enabled by defining WS2812_FRAME_CTRL_GLITCH_FILTER_EN.
module ws2812_frame_ctrl #(
  parameter int unsigned BITS_PER_PIXEL = 24,
  parameter int unsigned BIT1_THRESHOLD = timing_constants::BIT1_THRESHOLD,
  parameter int unsigned RESET_CYCLES   = timing_constants::RESET_CYCLES,
  parameter int unsigned CNT_W          = 12
) (
  input logic                 i_clk,
  input logic                 i_reset,
  ws2812_frame_ctrl_if.master ctrl
);

  import timing_constants::frame_state_t;
  import timing_constants::SYNC;
  import timing_constants::IDLE;
  import timing_constants::HIGH;
  import timing_constants::LOW;
  import timing_constants::PASS;
`ifdef WS2812_FRAME_CTRL_GLITCH_FILTER_EN
  import timing_constants::T0H_CYCLES_ENCODER_MIN;
  localparam logic [CNT_W-1:0] GlitchCnt = CNT_W'(T0H_CYCLES_ENCODER_MIN);
`endif

  localparam int unsigned      BCW      = $clog2(BITS_PER_PIXEL + 1);
  localparam logic [CNT_W-1:0] LatchCnt = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] Bit1Cnt  = CNT_W'(BIT1_THRESHOLD);
  localparam logic [BCW-1:0]   LastBit  = BCW'(BITS_PER_PIXEL - 1);

  logic             level, rise, fall;
  logic [CNT_W-1:0] cnt;

  pulse_timer #(
    .CNT_W (CNT_W)
  ) u_pulse_timer (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .sig_i   (ctrl.i_signal_synced),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall),
    .cnt_o   (cnt)
  );

  frame_state_t              state_q, state_d;
  logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
  logic [BITS_PER_PIXEL-1:0] pixel_q, pixel_d;
  logic                      passthru_q, passthru_d;
  logic                      valid_q, valid_d;
  logic                      err_q, err_d;
  logic                      latch, bit_val, glitch;

  // A rising edge in the latch cycle leaves level low but sets rise, so it wins.
  assign latch   = ~level & ~rise & (cnt == LatchCnt);
  assign bit_val = (cnt >= Bit1Cnt);
`ifdef WS2812_FRAME_CTRL_GLITCH_FILTER_EN
  assign glitch  = (cnt < GlitchCnt);
`else
  assign glitch  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pixel_d   = pixel_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      SYNC: begin
        if (latch) state_d = IDLE;
      end
      IDLE: begin
        bit_cnt_d = '0;
        shift_d   = '0;
        if (rise) state_d = HIGH;
      end
      HIGH: begin
        if (fall) begin
          if (glitch) begin
            state_d = (bit_cnt_q == '0) ? IDLE : LOW;
          end else begin
            shift_d   = {shift_q[BITS_PER_PIXEL-2:0], bit_val};
            bit_cnt_d = bit_cnt_q + BCW'(1);
            state_d   = (bit_cnt_q == LastBit) ? PASS : LOW;
          end
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
        end else if (latch) begin
          err_d     = 1'b1;
          bit_cnt_d = '0;
          shift_d   = '0;
          state_d   = IDLE;
        end
      end
      PASS: begin
        // Edges here belong to downstream pixels; only the latch matters.
        if (latch) begin
          pixel_d = shift_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = SYNC;
    endcase
    passthru_d = (state_d == PASS);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= SYNC;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      pixel_q    <= '0;
      passthru_q <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      pixel_q    <= pixel_d;
      passthru_q <= passthru_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign ctrl.o_passthru_en = passthru_q;
  assign ctrl.o_pixel       = pixel_q;
  assign ctrl.o_pixel_valid = valid_q;
  assign ctrl.o_frame_err   = err_q;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Scoreboard bench for ws2812_frame_ctrl: directed frames push expected pixel/error events,
// a monitor pops them whenever the DUT pulses o_pixel_valid or o_frame_err.
module tb_ws2812_frame_ctrl;

  localparam int unsigned Bpp = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ws2812_frame_ctrl_if #(.BITS_PER_PIXEL(Bpp)) bus ();

  ws2812_frame_ctrl #(
    .BITS_PER_PIXEL (Bpp),
    .BIT1_THRESHOLD (32),
    .RESET_CYCLES   (2500),
    .CNT_W          (12)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .ctrl    (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           is_err;
    logic [Bpp-1:0] pixel;
  } exp_t;

  exp_t           sb_q[$];
  int unsigned    n_checks = 0;
  int unsigned    n_pass   = 0;
  logic [Bpp-1:0] model_pixel = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int unsigned low_len(input logic b);
    return b ? 20 : 44;
  endfunction

  task automatic pulse_high(input int unsigned h);
    bus.i_signal_synced = 1'b1;
    repeat (h) @(negedge clk);
  endtask

  task automatic hold_low(input int unsigned l);
    bus.i_signal_synced = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    pulse_high(b ? 40 : 16);
    hold_low(low_len(b));
  endtask

  task automatic send_word(input logic [Bpp-1:0] w, input int unsigned nbits);
    for (int i = 0; i < int'(nbits); i++) send_bit(w[Bpp-1-i]);
  endtask

  // Final pixel bit: passthrough must rise exactly one cycle after its falling edge.
  task automatic send_last_bit(input logic b);
    pulse_high(b ? 40 : 16);
    bus.i_signal_synced = 1'b0;
    check("pt_before_last_fall", {31'd0, bus.o_passthru_en}, 32'd0);
    @(negedge clk);
    check("pt_after_last_fall", {31'd0, bus.o_passthru_en}, 32'd1);
    repeat (low_len(b) - 1) @(negedge clk);
  endtask

  // Hold low until the DUT reports an event; exp_n is the expected number of cycles.
  task automatic latch_wait(input string name, input int unsigned exp_n);
    int unsigned n = 0;
    bus.i_signal_synced = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.o_pixel_valid || bus.o_frame_err) && n < 3000);
    check(name, n, exp_n);
  endtask

  function automatic exp_t mk(input logic is_err, input logic [Bpp-1:0] px);
    exp_t e;
    e.is_err = is_err;
    e.pixel  = px;
    return e;
  endfunction

  // Monitor: sampled just after the falling edge so stimulus for the cycle is visible.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (bus.o_pixel_valid || bus.o_frame_err) begin
          check("valid_err_exclusive", {31'd0, bus.o_pixel_valid & bus.o_frame_err}, 32'd0);
          if (sb_q.size() == 0) begin
            check("unexpected_event", {30'd0, bus.o_pixel_valid, bus.o_frame_err}, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("event_is_err", {31'd0, bus.o_frame_err}, {31'd0, e.is_err});
            check("event_is_valid", {31'd0, bus.o_pixel_valid}, {31'd0, ~e.is_err});
            if (!e.is_err) begin
              check("pixel_value", {8'd0, bus.o_pixel}, {8'd0, e.pixel});
              check("pt_falls_with_valid", {31'd0, bus.o_passthru_en}, 32'd0);
              model_pixel = e.pixel;
            end else begin
              check("pixel_kept_on_err", {8'd0, bus.o_pixel}, {8'd0, model_pixel});
            end
          end
        end else begin
          check("pixel_hold", {8'd0, bus.o_pixel}, {8'd0, model_pixel});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [Bpp-1:0] p;
    logic [Bpp-1:0] q;
    logic [Bpp-1:0] w;

    bus.i_signal_synced = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_passthru", {31'd0, bus.o_passthru_en}, 32'd0);
    check("rst_pixel", {8'd0, bus.o_pixel}, 32'd0);
    check("rst_valid", {31'd0, bus.o_pixel_valid}, 32'd0);
    check("rst_err", {31'd0, bus.o_frame_err}, 32'd0);
    rst = 1'b0;
    hold_low(2600);

    // Exact-length frame.
    w = 24'hA5C30F;
    sb_q.push_back(mk(1'b0, w));
    send_word(w, 23);
    send_last_bit(w[0]);
    latch_wait("latch_a5c30f", 2501 - low_len(w[0]));

    // 72-bit frame: only the first 24 bits are kept, passthrough held throughout.
    w = 24'h123456;
    sb_q.push_back(mk(1'b0, w));
    send_word(w, 23);
    send_last_bit(w[0]);
    w = 24'hFFFF00;
    for (int i = 0; i < 24; i++) begin
      send_bit(w[23-i]);
      check("pt_hold_bits25_48", {31'd0, bus.o_passthru_en}, 32'd1);
    end
    w = 24'h0F0F0F;
    for (int i = 0; i < 24; i++) begin
      send_bit(w[23-i]);
      check("pt_hold_bits49_72", {31'd0, bus.o_passthru_en}, 32'd1);
    end
    latch_wait("latch_72bit", 2501 - low_len(w[0]));

    // Partial frame then latch: frame error, pixel kept.
    w = 24'hABCDEF;
    sb_q.push_back(mk(1'b1, '0));
    send_word(w, 10);
    latch_wait("latch_partial", 2501 - low_len(w[14]));

    // Reset while in passthrough at bit 30.
    w = 24'h0F1E2D;
    send_word(w, 24);
    send_word(24'hFFFFFF, 5);
    pulse_high(10);
    check("pt_in_pass_bit30", {31'd0, bus.o_passthru_en}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("pt_after_reset", {31'd0, bus.o_passthru_en}, 32'd0);
    check("pixel_after_reset", {8'd0, bus.o_pixel}, 32'd0);
    model_pixel = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Data with no preceding latch is ignored until the first long low.
    send_word(24'hFFFFFF, 24);
    send_word(24'h0000FF, 24);
    hold_low(2600);
    check("no_capture_before_sync", {8'd0, bus.o_pixel}, 32'd0);
    w = 24'h00FF81;
    sb_q.push_back(mk(1'b0, w));
    send_word(w, 23);
    send_last_bit(w[0]);
    latch_wait("latch_after_sync", 2501 - low_len(w[0]));

    // Three-cycle glitch between bits 5 and 6.
    p = 24'h5A3CF0;
`ifdef WS2812_FRAME_CTRL_GLITCH_FILTER_EN
    q = p;
`else
    q = {p[23:19], 1'b0, p[18:1]};
`endif
    sb_q.push_back(mk(1'b0, q));
    send_word(p, 5);
    pulse_high(3);
    hold_low(20);
    for (int i = 5; i < 24; i++) send_bit(p[23-i]);
    latch_wait("latch_glitch", 2501 - low_len(p[0]));

    // Stuck-high first bit longer than the counter range decodes as 1.
    p = 24'h800000;
    sb_q.push_back(mk(1'b0, p));
    pulse_high(4116);
    hold_low(20);
    for (int i = 1; i < 24; i++) send_bit(p[23-i]);
    latch_wait("latch_stuck_high", 2501 - low_len(p[0]));

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
